// File: rtl/branch_resolve_queue_pkg.sv
// branch_resolve_queue_pkg: shared widths, queue entry type and counter ceiling
package branch_resolve_queue_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_CNT_WIDTH = 32;
  localparam logic [DEF_CNT_WIDTH-1:0] CNT_MAX = '1;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] pc;
    logic pred;
  } entry_t;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: fetch/execute side signals of the branch resolve queue
interface branch_resolve_queue_if
  import branch_resolve_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PTR_WIDTH = 2,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
  logic enq_valid;
  logic [DATA_WIDTH-1:0] enq_pc;
  logic enq_pred;
  logic enq_ready;
  logic res_valid;
  logic res_taken;
  logic update;
  logic actually_taken;
  logic [DATA_WIDTH-1:0] resolved_pc;
  logic mispredict;
  logic [PTR_WIDTH:0] occupancy;
  logic underflow_err;
  logic [CNT_WIDTH-1:0] branch_cnt;
  logic [CNT_WIDTH-1:0] mispred_cnt;
  modport master (
    output enq_valid, enq_pc, enq_pred, res_valid, res_taken,
    input enq_ready, update, actually_taken, resolved_pc, mispredict,
    input occupancy, underflow_err, branch_cnt, mispred_cnt
  );
  modport slave (
    input enq_valid, enq_pc, enq_pred, res_valid, res_taken,
    output enq_ready, update, actually_taken, resolved_pc, mispredict,
    output occupancy, underflow_err, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_queue_sat_counter.sv
// sat_counter: increment-enable counter that holds at all-ones
module sat_counter
  import branch_resolve_queue_pkg::*;
#(
  parameter int W = DEF_CNT_WIDTH
) (
  input logic clk,
  input logic rst,
  input logic inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (inc && q != CNT_MAX[W-1:0]) q <= q + 1'b1;
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of predicted branches with resolve, flush and stats
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = 4,
  parameter int PTR_WIDTH = 2,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic clk,
  input logic rst,
  branch_resolve_queue_if.slave bus
);
  entry_t mem [DEPTH];
  entry_t hd;
  logic [PTR_WIDTH-1:0] head, tail;
  logic [PTR_WIDTH:0] occ;
  logic push, pop, miss;
  assign hd = mem[head];
  assign bus.enq_ready = occ != (PTR_WIDTH+1)'(DEPTH);
  assign bus.occupancy = occ;
  assign push = bus.enq_valid & bus.enq_ready;
  assign pop = bus.res_valid & (occ != '0);
  assign miss = pop & (hd.pred != bus.res_taken);
  always_ff @(posedge clk)
    if (push && !miss) mem[tail] <= '{pc: bus.enq_pc, pred: bus.enq_pred};
  always_ff @(posedge clk)
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ <= '0;
      bus.update <= 1'b0;
      bus.mispredict <= 1'b0;
      bus.actually_taken <= 1'b0;
      bus.resolved_pc <= '0;
      bus.underflow_err <= 1'b0;
    end else begin
      bus.update <= pop;
      bus.mispredict <= miss;
      bus.underflow_err <= bus.underflow_err | (bus.res_valid & (occ == '0));
      if (pop) begin
        bus.actually_taken <= bus.res_taken;
        bus.resolved_pc <= hd.pc;
        head <= head + 1'b1;
      end
      tail <= miss ? head + 1'b1 : push ? tail + 1'b1 : tail;
      occ <= miss ? '0 : occ + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
    end
  sat_counter #(.W(CNT_WIDTH)) u_branch_cnt (.clk(clk), .rst(rst), .inc(pop), .q(bus.branch_cnt));
  sat_counter #(.W(CNT_WIDTH)) u_mispred_cnt (.clk(clk), .rst(rst), .inc(miss), .q(bus.mispred_cnt));
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed and random checks against a queue-based model
module tb_branch_resolve_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  branch_resolve_queue_if #(.CNT_WIDTH(3)) b ();
  branch_resolve_queue_if b32 ();
  assign b32.enq_valid = b.enq_valid;
  assign b32.enq_pc = b.enq_pc;
  assign b32.enq_pred = b.enq_pred;
  assign b32.res_valid = b.res_valid;
  assign b32.res_taken = b.res_taken;
  branch_resolve_queue #(.CNT_WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  branch_resolve_queue dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  typedef struct {
    logic [31:0] pc;
    logic pred;
  } ent_t;
  ent_t q[$];
  int n_br, n_mp, passed, total;
  logic m_upd, m_mp, m_at, m_uf;
  logic [31:0] m_rpc;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic check_all();
    chk("update", 64'(b.update), 64'(m_upd));
    chk("mispredict", 64'(b.mispredict), 64'(m_mp));
    chk("actually_taken", 64'(b.actually_taken), 64'(m_at));
    chk("resolved_pc", 64'(b.resolved_pc), 64'(m_rpc));
    chk("occupancy", 64'(b.occupancy), 64'(q.size()));
    chk("enq_ready", 64'(b.enq_ready), 64'(q.size() < 4));
    chk("underflow_err", 64'(b.underflow_err), 64'(m_uf));
    chk("branch_cnt3", 64'(b.branch_cnt), 64'(n_br > 7 ? 7 : n_br));
    chk("mispred_cnt3", 64'(b.mispred_cnt), 64'(n_mp > 7 ? 7 : n_mp));
    chk("branch_cnt32", 64'(b32.branch_cnt), 64'(n_br));
    chk("mispred_cnt32", 64'(b32.mispred_cnt), 64'(n_mp));
    chk("update32", 64'(b32.update), 64'(m_upd));
    chk("resolved_pc32", 64'(b32.resolved_pc), 64'(m_rpc));
  endtask
  task automatic do_reset(logic ev, logic rv);
    rst = 1'b1;
    b.enq_valid = ev;
    b.enq_pc = 32'h1234;
    b.enq_pred = 1'b1;
    b.res_valid = rv;
    b.res_taken = 1'b0;
    q.delete();
    n_br = 0;
    n_mp = 0;
    m_upd = 0;
    m_mp = 0;
    m_at = 0;
    m_uf = 0;
    m_rpc = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    b.enq_valid = 1'b0;
    b.res_valid = 1'b0;
    check_all();
  endtask
  task automatic step(logic ev, logic [31:0] pc, logic pr, logic rv, logic rt);
    ent_t e;
    bit ready;
    b.enq_valid = ev;
    b.enq_pc = pc;
    b.enq_pred = pr;
    b.res_valid = rv;
    b.res_taken = rt;
    ready = q.size() < 4;
    #1;
    chk("enq_ready_pre", 64'(b.enq_ready), 64'(ready));
    m_upd = 0;
    m_mp = 0;
    if (rv && q.size() == 0) m_uf = 1;
    else if (rv) begin
      e = q.pop_front();
      m_upd = 1;
      m_at = rt;
      m_rpc = e.pc;
      m_mp = e.pred != rt;
      n_br++;
      if (m_mp) n_mp++;
    end
    if (m_mp) q.delete();
    else if (ev && ready) q.push_back('{pc, pr});
    @(posedge clk);
    #1;
    b.enq_valid = 1'b0;
    b.res_valid = 1'b0;
    check_all();
  endtask
  initial begin
    b.enq_valid = 0;
    b.enq_pc = 0;
    b.enq_pred = 0;
    b.res_valid = 0;
    b.res_taken = 0;
    @(posedge clk);
    do_reset(1, 1);
    step(1, 32'h100, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 32'h100 + 32'(4 * i), 1'(i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1'(i));
    step(1, 32'h200, 0, 0, 0);
    step(1, 32'h204, 1, 0, 0);
    step(1, 32'h208, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    step(1, 32'h300, 1, 0, 0);
    step(0, 0, 0, 1, 1);
    step(1, 32'h400, 1, 0, 0);
    step(1, 32'h404, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(1, 32'h500, 1, 0, 0);
    step(1, 32'h504, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 32'h600, 0, 0, 0);
    do_reset(0, 0);
    for (int i = 0; i < 9; i++) begin
      step(1, 32'h700 + 32'(4 * i), 1, 0, 0);
      step(0, 0, 0, 1, 1);
    end
    for (int i = 0; i < 3; i++) step(1, 32'h800 + 32'(4 * i), 0, 0, 0);
    do_reset(1, 1);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight conditional-branch predictions, sitting between fetch (which consumes the gshare prediction) and execute (which resolves the branch).
- Captures PC and predicted direction at fetch. On resolution it pops the oldest entry and drives the predictor's update interface (update, actually_taken, resolved_pc).
- Flags mispredictions and squashes younger wrong-path entries.
- Keeps saturating branch and mispredict statistics counters.

Parameters:
- DATA_WIDTH, 32, PC width.
- DEPTH, 4, queue entries (power of two).
- PTR_WIDTH, 2, log2(DEPTH).
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high.
- enq_valid  in  1  fetch pushes a predicted branch this cycle.
- enq_pc  in  DATA_WIDTH  PC of the predicted branch.
- enq_pred  in  1  predicted direction (1 = taken).
- enq_ready  out  1  queue can accept a push (not full).
- res_valid  in  1  oldest outstanding branch resolved this cycle.
- res_taken  in  1  resolved direction.
- update  out  1  one-cycle pulse to predictor update port.
- actually_taken  out  1  resolved direction accompanying update.
- resolved_pc  out  DATA_WIDTH  PC of the resolved branch accompanying update.
- mispredict  out  1  one-cycle pulse, valid with update, when prediction was wrong.
- occupancy  out  PTR_WIDTH+1  current entry count.
- underflow_err  out  1  sticky: res_valid seen while queue empty.
- branch_cnt  out  CNT_WIDTH  resolved branches, saturating.
- mispred_cnt  out  CNT_WIDTH  mispredictions, saturating.

Behaviour:
- Reset values (rst high at posedge): all entries invalid; head = tail = 0; occupancy = 0; update = actually_taken = mispredict = 0; resolved_pc = 0; underflow_err = 0; both counters 0. Reset overrides every other input that cycle, including any in-progress push or resolve.
- enq_ready = (occupancy != DEPTH), combinational from registered occupancy. No same-cycle bypass: when full, enq_ready stays 0 even if res_valid is high.
- Push: enq_valid & enq_ready writes {enq_pc, enq_pred} at tail; tail increments modulo DEPTH (natural wrap of PTR_WIDTH bits). enq_valid while full is dropped; state is unchanged.
- Resolve with queue non-empty:
  - Head entry read.
  - Next cycle: update = 1, actually_taken = res_taken, resolved_pc = head PC, mispredict = (head pred != res_taken). Latency is exactly 1 cycle.
  - Head increments; branch_cnt += 1 and, on mispredict, mispred_cnt += 1. Both hold at all-ones.
- Misprediction flush: on a mispredicting resolve, every younger entry is discarded. Tail = head + 1 (post-pop head), occupancy = 0. A push in the same cycle is also discarded, since it is wrong-path.
- Correct resolve and push in the same cycle: both take effect; occupancy unchanged.
- Resolve with queue empty: no update pulse, counters unchanged, underflow_err set and held until rst.
- Outputs update and mispredict are 0 in any cycle not immediately following a valid non-empty resolve. actually_taken and resolved_pc hold their last values otherwise.
- Occupancy changes: +1 on push only, -1 on correct resolve only, 0 on both, 0 after flush.

Decomposition:
- Shared package: DATA_WIDTH default, entry struct {pc, pred}, counter saturation max constant.
- One natural sub-module: sat_counter (CNT_WIDTH increment-enable saturating counter), instantiated twice.
- The FIFO storage stays inline.

Test Plan:
- Reset, then push pc=0x100 pred=1, resolve taken=1 -> next cycle update=1, resolved_pc=0x100, actually_taken=1, mispredict=0, branch_cnt=1, occupancy=0.
- Push 4 entries (0x100, 0x104, 0x108, 0x10C) -> enq_ready=0, occupancy=4; a 5th push of 0x110 is dropped; resolve 4 correct -> resolved_pc sequence 0x100, 0x104, 0x108, 0x10C.
- Push 0x200 pred=0, 0x204, 0x208; resolve 0x200 taken=1 -> mispredict=1, mispred_cnt=1, occupancy=0; next push 0x300 then resolve -> resolved_pc=0x300.
- Same-cycle push 0x404 and correct resolve of 0x400 -> occupancy unchanged at 1, next resolve gives 0x404. Same-cycle push and mispredicting resolve -> pushed entry dropped, occupancy=0.
- res_valid with empty queue -> no update pulse, underflow_err=1, which remains 1 until rst.
- Preload branch_cnt near all-ones via a small CNT_WIDTH=3 build; 9 resolves -> branch_cnt=7 (saturated). Assert rst mid-stream with occupancy=3 -> next cycle all outputs 0, enq_ready=1.
